// File: rtl/codec_clkgen_if.sv
// Codec clock/power-sequencing bundle: restart request in, codec pins and frame timing out.
// Latency: n/a (signal bundle only).
// Backpressure: none; all signals are free-running levels or single-cycle pulses.
// master = clock generator, slave = serializer/deserializer and control logic.
interface codec_clkgen_if #(
    parameter int IDX_W = 7
);
    logic             restart;
    logic             codec_pdn;
    logic             bclk;
    logic             lrck;
    logic             sample_strobe;
    logic [IDX_W-1:0] bit_index;
    logic             ready;

    modport master (
        input  restart,
        output codec_pdn,
        output bclk,
        output lrck,
        output sample_strobe,
        output bit_index,
        output ready
    );

    modport slave (
        output restart,
        input  codec_pdn,
        input  bclk,
        input  lrck,
        input  sample_strobe,
        input  bit_index,
        input  ready
    );
endinterface

// File: rtl/codec_clkgen.sv
// Codec power-up sequencer and TDM bit/frame clock generator.
// Latency: all outputs registered; restart takes effect on the cycle after it is sampled.
// Backpressure: none; free-running clocks, strobe is a one-cycle pulse per frame in RUN.
// Ports: clk_12m (system clock), rst_n (async active-low), bus (master modport:
//   restart in; codec_pdn, bclk, lrck, sample_strobe, bit_index, ready out).
module codec_clkgen #(
    parameter int BCLK_DIV_LOG2   = 1,
    parameter int FS_DIV_LOG2     = 8,
    parameter int PDN_HOLD_CYCLES = 1200,
    parameter int SETTLE_FRAMES   = 16
) (
    input  logic           clk_12m,
    input  logic           rst_n,
    codec_clkgen_if.master bus
);
    localparam int IDX_W  = FS_DIV_LOG2 - BCLK_DIV_LOG2;
    localparam int HOLD_W = $clog2(PDN_HOLD_CYCLES + 1);
    localparam int FRM_W  = $clog2(SETTLE_FRAMES + 1);

    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(PDN_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]      HOLD_ONE  = HOLD_W'(1);
    localparam logic [FRM_W-1:0]       FRM_LAST  = FRM_W'(SETTLE_FRAMES - 1);
    localparam logic [FRM_W-1:0]       FRM_ONE   = FRM_W'(1);
    localparam logic [FS_DIV_LOG2-1:0] CNT_ONE   = FS_DIV_LOG2'(1);

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_PDN_HOLD = 2'd1,
        S_SETTLE   = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    state_t                 state;
    logic [FS_DIV_LOG2-1:0] cnt;
    logic [FS_DIV_LOG2-1:0] cnt_n;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [FRM_W-1:0]       frame_cnt;

    logic             pdn_q;
    logic             bclk_q;
    logic             lrck_q;
    logic             strobe_q;
    logic [IDX_W-1:0] bidx_q;
    logic             ready_q;

    // Clock outputs are registered from the next count so they line up with cnt.
    assign cnt_n = cnt + CNT_ONE;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            cnt       <= '0;
            hold_cnt  <= '0;
            frame_cnt <= '0;
            pdn_q     <= 1'b0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            strobe_q  <= 1'b0;
            bidx_q    <= '0;
            ready_q   <= 1'b0;
        end else if (bus.restart && state != S_OFF) begin
            // Abandon whatever is in flight, including a partial frame.
            state     <= S_PDN_HOLD;
            cnt       <= '0;
            hold_cnt  <= '0;
            frame_cnt <= '0;
            pdn_q     <= 1'b0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            strobe_q  <= 1'b0;
            bidx_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state)
                S_OFF: begin
                    state <= S_PDN_HOLD;
                end
                S_PDN_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= S_SETTLE;
                        hold_cnt <= '0;
                        pdn_q    <= 1'b1;
                        // First settle cycle has cnt=0: lrck high, bclk low.
                        cnt      <= '0;
                        bclk_q   <= 1'b0;
                        lrck_q   <= 1'b1;
                        bidx_q   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                S_SETTLE, S_RUN: begin
                    cnt    <= cnt_n;
                    bclk_q <= cnt_n[BCLK_DIV_LOG2-1];
                    lrck_q <= ~cnt_n[FS_DIV_LOG2-1];
                    bidx_q <= cnt_n[FS_DIV_LOG2-1:BCLK_DIV_LOG2];
                    if (state == S_RUN) begin
                        strobe_q <= (cnt_n == '0);
                    end else if (cnt == '1) begin
                        frame_cnt <= frame_cnt + FRM_ONE;
                        // Last settle frame done: the wrap cycle is the first RUN frame start.
                        if (frame_cnt == FRM_LAST) begin
                            state    <= S_RUN;
                            ready_q  <= 1'b1;
                            strobe_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

    assign bus.codec_pdn     = pdn_q;
    assign bus.bclk          = bclk_q;
    assign bus.lrck          = lrck_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.bit_index     = bidx_q;
    assign bus.ready         = ready_q;
endmodule

// File: tb/tb_codec_clkgen.sv
module tb_codec_clkgen;
    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    codec_clkgen_if #(.IDX_W(7)) bus_a ();
    codec_clkgen_if #(.IDX_W(6)) bus_b ();

    codec_clkgen dut_a (
        .clk_12m (clk),
        .rst_n   (rst_a_n),
        .bus     (bus_a)
    );

    codec_clkgen #(
        .BCLK_DIV_LOG2   (2),
        .FS_DIV_LOG2     (8),
        .PDN_HOLD_CYCLES (4),
        .SETTLE_FRAMES   (1)
    ) dut_b (
        .clk_12m (clk),
        .rst_n   (rst_b_n),
        .bus     (bus_b)
    );

    typedef struct packed {
        logic       pdn;
        logic       bclk;
        logic       lrck;
        logic       strobe;
        logic       ready;
        logic [6:0] bidx;
    } obs_t;

    typedef struct {
        int dut;
        int off;
        int bclk;
        int lrck;
        int bidx;
    } vec_t;

    vec_t vt[16];

    function automatic obs_t obs(input int d);
        obs_t o;
        if (d == 0)
            o = '{bus_a.codec_pdn, bus_a.bclk, bus_a.lrck, bus_a.sample_strobe,
                  bus_a.ready, bus_a.bit_index};
        else
            o = '{bus_b.codec_pdn, bus_b.bclk, bus_b.lrck, bus_b.sample_strobe,
                  bus_b.ready, {1'b0, bus_b.bit_index}};
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until codec_pdn is seen high; counts samples with clocks active before that.
    task automatic wait_pdn(input int d, input int bound, output int n, output int clk_act);
        n = 0;
        clk_act = 0;
        while (!obs(d).pdn && n < bound) begin
            step();
            n++;
            if (!obs(d).pdn && (obs(d).bclk || obs(d).lrck)) clk_act++;
        end
        if (!obs(d).pdn) n = -1;
    endtask

    // Edges until ready is seen high; counts strobes seen while not ready.
    task automatic wait_ready(input int d, input int bound, output int n, output int strobes);
        n = 0;
        strobes = 0;
        while (!obs(d).ready && n < bound) begin
            step();
            n++;
            if (!obs(d).ready && obs(d).strobe) strobes++;
        end
        if (!obs(d).ready) n = -1;
    endtask

    task automatic run_table(input int first, input int last, input int base);
        int   guard;
        int   early;
        obs_t o;
        early = 0;
        for (int i = first; i <= last; i++) begin
            guard = 0;
            while (cyc - base < vt[i].off && guard < 10000) begin
                step();
                guard++;
                if (obs(vt[i].dut).ready) early++;
            end
            o = obs(vt[i].dut);
            check($sformatf("d%0d_bclk@%0d", vt[i].dut, vt[i].off), int'(o.bclk), vt[i].bclk);
            check($sformatf("d%0d_lrck@%0d", vt[i].dut, vt[i].off), int'(o.lrck), vt[i].lrck);
            check($sformatf("d%0d_bidx@%0d", vt[i].dut, vt[i].off), int'(o.bidx), vt[i].bidx);
        end
        check($sformatf("d%0d_ready_in_settle", vt[first].dut), early, 0);
    endtask

    initial begin
        int   n;
        int   ca;
        int   s;
        int   base;
        int   ready_at;
        int   e;
        obs_t o;

        // Default config: bclk=cnt[0], lrck=~cnt[7], bidx=cnt[7:1]; offset = cycles since pdn rise.
        vt[0]  = '{0,    0, 0, 1,   0};
        vt[1]  = '{0,    1, 1, 1,   0};
        vt[2]  = '{0,    2, 0, 1,   1};
        vt[3]  = '{0,  127, 1, 1,  63};
        vt[4]  = '{0,  128, 0, 0,  64};
        vt[5]  = '{0,  255, 1, 0, 127};
        vt[6]  = '{0,  256, 0, 1,   0};
        vt[7]  = '{0,  301, 1, 1,  22};
        vt[8]  = '{0, 4095, 1, 0, 127};
        // Override config: bclk=cnt[1], lrck=~cnt[7], bidx=cnt[7:2].
        vt[9]  = '{1,    0, 0, 1,   0};
        vt[10] = '{1,    1, 0, 1,   0};
        vt[11] = '{1,    2, 1, 1,   0};
        vt[12] = '{1,    4, 0, 1,   1};
        vt[13] = '{1,    6, 1, 1,   1};
        vt[14] = '{1,  130, 1, 0,  32};
        vt[15] = '{1,  255, 1, 0,  63};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.restart = 1'b0;
        bus_b.restart = 1'b0;

        repeat (3) step();
        o = obs(0);
        check("rst_pdn", int'(o.pdn), 0);
        check("rst_bclk", int'(o.bclk), 0);
        check("rst_lrck", int'(o.lrck), 0);
        check("rst_strobe", int'(o.strobe), 0);
        check("rst_ready", int'(o.ready), 0);
        check("rst_bidx", int'(o.bidx), 0);
        check("rst_b_all", int'(obs(1)), 0);

        // Power-up from reset release.
        @(negedge clk);
        rst_a_n = 1'b1;
        wait_pdn(0, 3000, n, ca);
        check("pdn_delay", n, 1201);
        check("clocks_idle_in_hold", ca, 0);
        base = cyc;
        for (int k = 0; k < 4; k++) exp_q.push_back(base + 4096 + 256 * k);

        run_table(0, 8, base);

        // Strobe scoreboard through settle completion and three more frames.
        ready_at = -1;
        while (cyc < base + 4096 + 768 + 20) begin
            step();
            o = obs(0);
            if (o.ready && ready_at < 0) begin
                ready_at = cyc - base;
                check("strobe_at_ready", int'(o.strobe), 1);
                check("bidx_at_ready", int'(o.bidx), 0);
            end
            if (o.strobe) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("extra_strobe@%0d", cyc - base), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_time", cyc - base, e - base);
                end
            end
        end
        check("ready_delay", ready_at, 4096);
        check("strobes_left", exp_q.size(), 0);

        // Restart mid-frame at bit_index 50.
        n = 0;
        while (obs(0).bidx != 50 && n < 600) begin
            step();
            n++;
        end
        check("found_bidx50", int'(obs(0).bidx), 50);
        bus_a.restart = 1'b1;
        step();
        bus_a.restart = 1'b0;
        o = obs(0);
        check("rs_ready", int'(o.ready), 0);
        check("rs_pdn", int'(o.pdn), 0);
        check("rs_bclk", int'(o.bclk), 0);
        check("rs_lrck", int'(o.lrck), 0);
        check("rs_strobe", int'(o.strobe), 0);
        wait_pdn(0, 3000, n, ca);
        check("rs_pdn_delay", n, 1200);
        check("rs_clocks_idle", ca, 0);
        wait_ready(0, 5000, n, s);
        check("rs_ready_delay", n, 4096);
        check("rs_settle_strobes", s, 0);

        // Async reset between edges mid-settle, then full replay.
        bus_a.restart = 1'b1;
        step();
        bus_a.restart = 1'b0;
        wait_pdn(0, 3000, n, ca);
        check("rs2_pdn_delay", n, 1200);
        repeat (1000) step();
        check("mid_settle_bclk_live", int'(obs(0).pdn), 1);
        #3;
        rst_a_n = 1'b0;
        #1;
        check("async_rst_outputs", int'(obs(0)), 0);
        @(negedge clk);
        rst_a_n = 1'b1;
        wait_pdn(0, 3000, n, ca);
        check("replay_pdn_delay", n, 1201);
        check("replay_clocks_idle", ca, 0);
        wait_ready(0, 5000, n, s);
        check("replay_ready_delay", n, 4096);
        check("replay_settle_strobes", s, 0);

        // Parameter override instance.
        @(negedge clk);
        rst_b_n = 1'b1;
        wait_pdn(1, 100, n, ca);
        check("b_pdn_delay", n, 5);
        check("b_clocks_idle", ca, 0);
        base = cyc;
        run_table(9, 15, base);
        wait_ready(1, 600, n, s);
        check("b_ready_delay", cyc - base, 256);
        check("b_strobe_at_ready", int'(obs(1).strobe), 1);
        check("b_bidx_at_ready", int'(obs(1).bidx), 0);
        check("b_settle_strobes", s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
